// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause bit positions.
package cp0_defs;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: SR/Cause/EPC/PRId,
// zero-latency flush request, mfc0/mtc0 access and eret EXL clearing.
module cp0_exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID    = 32'h2023_0001,
    parameter int          HWINT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         rd_addr,
    input  logic [4:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               wr_en,
    input  logic [31:0]        vpc,
    input  logic               bd_in,
    input  logic [4:0]         exc_in,
    input  logic [HWINT_W-1:0] hw_int,
    input  logic               exl_clr,
    output logic [31:0]        rd_data,
    output logic [31:0]        epc_out,
    output logic               req
);

    logic [HWINT_W-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic [HWINT_W-1:0] ip_q;
    logic [4:0]         code_q, code_d;
    logic [31:0]        epc_q, epc_d;

    logic        int_req, exc_req;
    logic [31:0] victim_pc;
    logic [31:0] sr_val, cause_val;

    assign int_req = ie_q & ~exl_q & |(hw_int & im_q);
    assign exc_req = (exc_in != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;

    // A delay-slot victim restarts at its branch; subtraction wraps modulo 2^32.
    assign victim_pc = bd_in ? (vpc - 32'd4) : vpc;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        if (req) begin
            exl_d  = 1'b1;
            bd_d   = bd_in;
            code_d = int_req ? EXC_INT : exc_in;
            epc_d  = victim_pc & ~32'd3;
        end else begin
            if (wr_en && wr_addr == REG_SR) begin
                im_d  = wr_data[SR_IM_LO +: HWINT_W];
                exl_d = wr_data[SR_EXL];
                ie_d  = wr_data[SR_IE];
            end
            if (wr_en && wr_addr == REG_EPC) begin
                epc_d = wr_data;
            end
            if (exl_clr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= hw_int;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    always_comb begin
        sr_val                            = 32'd0;
        sr_val[SR_IM_LO +: HWINT_W]       = im_q;
        sr_val[SR_EXL]                    = exl_q;
        sr_val[SR_IE]                     = ie_q;
        cause_val                         = 32'd0;
        cause_val[CAUSE_BD]               = bd_q;
        cause_val[CAUSE_IP_LO +: HWINT_W] = ip_q;
        cause_val[CAUSE_EXC_LO +: 5]      = code_q;
    end

    always_comb begin
        case (rd_addr)
            REG_SR:    rd_data = sr_val;
            REG_CAUSE: rd_data = cause_val;
            REG_EPC:   rd_data = epc_q;
            REG_PRID:  rd_data = PRID;
            default:   rd_data = 32'd0;
        endcase
    end

    // Lets an eret directly behind an mtc0 EPC see the new target without a stall.
    assign epc_out = (wr_en && wr_addr == REG_EPC && !req) ? wr_data : epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr, wr_addr, exc_in;
    logic [31:0] wr_data, vpc;
    logic        wr_en, bd_in, exl_clr;
    logic [5:0]  hw_int;
    logic [31:0] rd_data, epc_out;
    logic        req;

    int passed = 0;
    int total  = 0;

    cp0_exc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .vpc     (vpc),
        .bd_in   (bd_in),
        .exc_in  (exc_in),
        .hw_int  (hw_int),
        .exl_clr (exl_clr),
        .rd_data (rd_data),
        .epc_out (epc_out),
        .req     (req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; exc_in = 0; bd_in = 0;
        vpc = 0; hw_int = 0; exl_clr = 0;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        total++;
        if (rd_data !== exp) $display("FAIL %s: got %h expected %h", name, rd_data, exp);
        else passed++;
    endtask

    task automatic chk_req(input string name, input logic exp);
        #1;
        total++;
        if (req !== exp) $display("FAIL %s: req got %b expected %b", name, req, exp);
        else passed++;
    endtask

    task automatic chk_epc_out(input string name, input logic [31:0] exp);
        #1;
        total++;
        if (epc_out !== exp) $display("FAIL %s: epc_out got %h expected %h", name, epc_out, exp);
        else passed++;
    endtask

    task automatic clear_exl();
        idle_inputs();
        exl_clr = 1;
        step();
        exl_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr = 0;
        reset = 0;
        hw_int = 6'b111111;
        #12;
        chk_reg("reset_sr", 5'd12, 32'h0);
        chk_reg("reset_cause", 5'd13, 32'h0);
        chk_reg("reset_epc", 5'd14, 32'h0);
        chk_reg("reset_prid", 5'd15, 32'h2023_0001);
        chk_reg("reset_other", 5'd3, 32'h0);
        chk_req("reset_req", 1'b0);
        chk_epc_out("reset_epc_out", 32'h0);
        hw_int = 0;
        @(negedge clk);
        reset = 1;
        step();
    endtask

    task automatic test_interrupt();
        idle_inputs();
        wr_en = 1; wr_addr = 5'd12; wr_data = 32'hFFFF_FFFF;
        step();
        chk_reg("sr_write_mask", 5'd12, 32'h0000_FC03);
        wr_data = 32'h0000_0401;
        step();
        wr_en = 0;
        chk_reg("sr_write", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; vpc = 32'h0000_1000;
        chk_req("int_req", 1'b1);
        step();
        chk_req("int_req_after", 1'b0);
        chk_reg("int_cause", 5'd13, 32'h0000_0400);
        chk_reg("int_sr_exl", 5'd12, 32'h0000_0403);
        chk_reg("int_epc", 5'd14, 32'h0000_1000);
        clear_exl();
        chk_reg("eret_sr", 5'd12, 32'h0000_0401);
        chk_reg("ip_follows", 5'd13, 32'h0000_0000);
    endtask

    task automatic test_exception_bd();
        idle_inputs();
        exc_in = 5'd12; bd_in = 1; vpc = 32'h0000_3010;
        chk_req("exc_req", 1'b1);
        step();
        chk_reg("exc_epc_bd", 5'd14, 32'h0000_300C);
        chk_reg("exc_cause", 5'd13, 32'h8000_0030);
        chk_req("exc_held_exl", 1'b0);
        clear_exl();
        exc_in = 5'd8; bd_in = 1; vpc = 32'h0000_0002;
        chk_req("wrap_req", 1'b1);
        step();
        chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        chk_reg("wrap_cause", 5'd13, 32'h8000_0020);
        clear_exl();
    endtask

    task automatic test_priority();
        idle_inputs();
        exc_in = 5'd4; hw_int = 6'b000001; vpc = 32'h0000_2000;
        chk_req("prio_req", 1'b1);
        step();
        chk_reg("prio_cause", 5'd13, 32'h0000_0400);
        chk_reg("prio_epc", 5'd14, 32'h0000_2000);
        clear_exl();
    endtask

    task automatic test_nested();
        idle_inputs();
        exc_in = 5'd5; vpc = 32'h0000_0500;
        step();
        chk_reg("nest_first_cause", 5'd13, 32'h0000_0014);
        exc_in = 5'd10; vpc = 32'h0000_0600; bd_in = 1;
        chk_req("nest_req_blocked", 1'b0);
        step();
        idle_inputs();
        chk_reg("nest_cause_kept", 5'd13, 32'h0000_0014);
        chk_reg("nest_epc_kept", 5'd14, 32'h0000_0500);
        chk_reg("nest_sr_kept", 5'd12, 32'h0000_0403);
        exl_clr = 1; wr_en = 1; wr_addr = 5'd12; wr_data = 32'h0000_0403;
        step();
        idle_inputs();
        chk_reg("exl_clr_wins", 5'd12, 32'h0000_0401);
    endtask

    task automatic test_epc_forward();
        idle_inputs();
        wr_en = 1; wr_addr = 5'd14; wr_data = 32'h0000_3100;
        chk_epc_out("fwd_same_cycle", 32'h0000_3100);
        chk_reg("fwd_no_bypass", 5'd14, 32'h0000_0500);
        step();
        wr_en = 0;
        chk_reg("fwd_epc_written", 5'd14, 32'h0000_3100);
        chk_epc_out("fwd_epc_out_reg", 32'h0000_3100);
        wr_en = 1; wr_addr = 5'd14; wr_data = 32'h7777_0000;
        exc_in = 5'd12; vpc = 32'h0000_4000;
        chk_req("supp_req", 1'b1);
        chk_epc_out("supp_epc_out", 32'h0000_3100);
        step();
        chk_reg("supp_epc", 5'd14, 32'h0000_4000);
        chk_reg("supp_cause", 5'd13, 32'h0000_0030);
        clear_exl();
        wr_en = 1; wr_addr = 5'd13; wr_data = 32'hFFFF_FFFF;
        step();
        wr_addr = 5'd15;
        step();
        idle_inputs();
        chk_reg("cause_ro", 5'd13, 32'h0000_0030);
        chk_reg("prid_ro", 5'd15, 32'h2023_0001);
    endtask

    task automatic test_reset_mid_handler();
        idle_inputs();
        hw_int = 6'b000001; vpc = 32'h0000_0800;
        chk_req("mid_req_before", 1'b1);
        #1;
        reset = 0;
        chk_req("mid_req_dropped", 1'b0);
        chk_reg("mid_sr", 5'd12, 32'h0);
        chk_reg("mid_cause", 5'd13, 32'h0);
        chk_reg("mid_epc", 5'd14, 32'h0);
        @(negedge clk);
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_priority();
        test_nested();
        test_epc_forward();
        test_reset_mid_handler();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
